pong_ball_engine: RTL

//  Upstream stage of the VGA colour mux. Owns the ball: position, velocity, wall/paddle

---
 rtl/pong_ball_engine.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pong_ball_engine.sv
// pong_ball_engine: owns the ball position, velocity, wall/paddle bounces, misses and serve.
// Position advances once per frame on the first vertical-blanking line.
module pong_ball_engine #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int BALL_SIZE    = 8,
    parameter int SPEED        = 2,
    parameter int P1_X         = 50,
    parameter int P2_X         = 590,
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_H     = 80,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       vga_clk,
    input  logic       rst_n,
    input  logic [9:0] hsp,
    input  logic [9:0] vsp,
    input  logic [9:0] p1_y,
    input  logic [9:0] p2_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       ball_intersect,
    output logic       p1_score,
    output logic       p2_score,
    output logic       in_play
);
    localparam logic [10:0] C_SPEED  = 11'(SPEED);
    localparam logic [10:0] C_BALL   = 11'(BALL_SIZE);
    localparam logic [10:0] C_PAD_H  = 11'(PADDLE_H);
    localparam logic [10:0] C_X_MAX  = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] C_Y_MAX  = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [10:0] C_L_FACE = 11'(P1_X + PADDLE_W);
    localparam logic [10:0] C_R_FACE = 11'(P2_X);
    localparam logic [9:0]  C_X_CTR  = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]  C_Y_CTR  = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]  C_TICK_V = 10'(V_ACTIVE);
    localparam int          CNT_W    = $clog2(SERVE_FRAMES);
    localparam logic [CNT_W-1:0] C_SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    typedef enum logic [1:0] {
        S_SERVE = 2'd0,
        S_PLAY  = 2'd1,
        S_MISS  = 2'd2
    } state_t;

    state_t           r_state;
    logic [9:0]       r_ball_x;
    logic [9:0]       r_ball_y;
    logic             r_dx_pos;
    logic             r_dy_pos;
    logic [CNT_W-1:0] r_serve_cnt;
    logic             r_p1_score;
    logic             r_p2_score;
    logic             r_in_play;

    logic        w_tick;
    logic [10:0] w_x;
    logic [10:0] w_y;
    logic [10:0] w_p1;
    logic [10:0] w_p2;
    logic        w_ov1;
    logic        w_ov2;
    logic [9:0]  w_nx;
    logic [9:0]  w_ny;
    logic        w_ndx;
    logic        w_ndy;
    logic        w_miss_l;
    logic        w_miss_r;

    assign w_tick = (hsp == 10'd0) && (vsp == C_TICK_V);
    assign w_x    = {1'b0, r_ball_x};
    assign w_y    = {1'b0, r_ball_y};
    assign w_p1   = {1'b0, p1_y};
    assign w_p2   = {1'b0, p2_y};

    // 11-bit sums keep an out-of-range paddle from wrapping into a false overlap
    assign w_ov1 = (w_y + C_BALL > w_p1) && (w_y < w_p1 + C_PAD_H);
    assign w_ov2 = (w_y + C_BALL > w_p2) && (w_y < w_p2 + C_PAD_H);

    assign ball_intersect = ({1'b0, hsp} >= w_x) && ({1'b0, hsp} < w_x + C_BALL) &&
                            ({1'b0, vsp} >= w_y) && ({1'b0, vsp} < w_y + C_BALL);

    always_comb begin
        w_ny  = r_ball_y;
        w_ndy = r_dy_pos;
        if (r_dy_pos) begin
            if (w_y + C_SPEED > C_Y_MAX) begin
                w_ny  = 10'(C_Y_MAX);
                w_ndy = 1'b0;
            end else begin
                w_ny = 10'(w_y + C_SPEED);
            end
        end else begin
            if (w_y < C_SPEED) begin
                w_ny  = 10'd0;
                w_ndy = 1'b1;
            end else begin
                w_ny = 10'(w_y - C_SPEED);
            end
        end
    end

    always_comb begin
        w_nx     = r_ball_x;
        w_ndx    = r_dx_pos;
        w_miss_l = 1'b0;
        w_miss_r = 1'b0;
        if (!r_dx_pos) begin
            if ((w_x >= C_L_FACE) && (w_x - C_SPEED < C_L_FACE) && w_ov1) begin
                w_nx  = 10'(C_L_FACE);
                w_ndx = 1'b1;
            end else if (w_x < C_SPEED) begin
                w_miss_l = 1'b1;
            end else begin
                w_nx = 10'(w_x - C_SPEED);
            end
        end else begin
            if ((w_x + C_BALL <= C_R_FACE) && (w_x + C_BALL + C_SPEED > C_R_FACE) && w_ov2) begin
                w_nx  = 10'(C_R_FACE - C_BALL);
                w_ndx = 1'b0;
            end else if (w_x + C_SPEED > C_X_MAX) begin
                w_miss_r = 1'b1;
            end else begin
                w_nx = 10'(w_x + C_SPEED);
            end
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_SERVE;
            r_ball_x    <= C_X_CTR;
            r_ball_y    <= C_Y_CTR;
            r_dx_pos    <= 1'b1;
            r_dy_pos    <= 1'b1;
            r_serve_cnt <= '0;
            r_p1_score  <= 1'b0;
            r_p2_score  <= 1'b0;
            r_in_play   <= 1'b0;
        end else begin
            r_p1_score <= 1'b0;
            r_p2_score <= 1'b0;
            case (r_state)
                S_SERVE: begin
                    if (w_tick) begin
                        if (r_serve_cnt == C_SERVE_LAST) begin
                            r_state     <= S_PLAY;
                            r_in_play   <= 1'b1;
                            r_serve_cnt <= '0;
                        end else begin
                            r_serve_cnt <= r_serve_cnt + 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (w_tick) begin
                        r_ball_y <= w_ny;
                        r_dy_pos <= w_ndy;
                        if (w_miss_l) begin
                            r_state    <= S_MISS;
                            r_in_play  <= 1'b0;
                            r_p2_score <= 1'b1;
                        end else if (w_miss_r) begin
                            r_state    <= S_MISS;
                            r_in_play  <= 1'b0;
                            r_p1_score <= 1'b1;
                        end else begin
                            r_ball_x <= w_nx;
                            r_dx_pos <= w_ndx;
                        end
                    end
                end
                S_MISS: begin
                    // serve heads toward whoever lost the point
                    r_ball_x <= C_X_CTR;
                    r_ball_y <= C_Y_CTR;
                    r_dx_pos <= r_p1_score;
                    r_state  <= S_SERVE;
                end
                default: begin
                    r_state   <= S_SERVE;
                    r_in_play <= 1'b0;
                end
            endcase
        end
    end

    assign ball_x   = r_ball_x;
    assign ball_y   = r_ball_y;
    assign p1_score = r_p1_score;
    assign p2_score = r_p2_score;
    assign in_play  = r_in_play;

endmodule
